// File: rtl/joy_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// joy_paddle_ctrl
//
// Turns raw PmodJSTK y-axis samples into a clamped paddle position for one
// player. Samples are smoothed, a dead zone around the neutral reading is
// applied, and the paddle steps once per video frame while the game is in
// play. Instantiate once per player between the SPI reader and the renderer.
//
// Optional feature (macro JOY_FILTER_EN):
//   defined   : 4-tap moving average; the filter is primed after 4 samples.
//   undefined : no sample buffer; avg_y is the last sample, registered, and
//               the filter is primed after the first sample.
//
// Ports:
//   clk          in   master clock (50 MHz), all state on rising edge
//   clr          in   synchronous active-high reset, highest priority
//   sample_valid in   one-cycle strobe, joy_y valid this cycle
//   joy_y        in   raw 10-bit joystick y reading
//   frame_tick   in   one-cycle strobe per VGA frame
//   enable       in   high while the game is in the play state
//   recenter     in   one-cycle strobe, return paddle to PAD_INIT
//   pad_y        out  paddle top y coordinate
//   avg_y        out  filtered joystick reading
//   moving_up    out  last frame step decreased pad_y
//   moving_down  out  last frame step increased pad_y
//   ready        out  filter primed (TRACK state)
// -----------------------------------------------------------------------------
module joy_paddle_ctrl #(
    parameter int DATA_W      = 10,
    parameter int JOY_CENTER  = 512,
    parameter int DEAD_ZONE   = 64,
    parameter int FAST_THRESH = 256,
    parameter int SPEED_SLOW  = 2,
    parameter int SPEED_FAST  = 6,
    parameter int PAD_MIN     = 0,
    parameter int PAD_MAX     = 400,
    parameter int PAD_INIT    = 200
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] joy_y,
    input  logic              frame_tick,
    input  logic              enable,
    input  logic              recenter,
    output logic [DATA_W-1:0] pad_y,
    output logic [DATA_W-1:0] avg_y,
    output logic              moving_up,
    output logic              moving_down,
    output logic              ready
);

    // One extra bit so deviation and pad arithmetic are signed without
    // wrapping (pad_y < step must go negative, not wrap to a large value).
    localparam int SW = DATA_W + 1;

    localparam logic [DATA_W-1:0]        CENTER_U = DATA_W'(JOY_CENTER);
    localparam logic [DATA_W-1:0]        INIT_U   = DATA_W'(PAD_INIT);
    localparam logic signed [SW-1:0]     CENTER_S = SW'(JOY_CENTER);
    localparam logic [SW-1:0]            DZ_U     = SW'(DEAD_ZONE);
    localparam logic [SW-1:0]            FAST_U   = SW'(FAST_THRESH);
    localparam logic signed [SW-1:0]     SLOW_S   = SW'(SPEED_SLOW);
    localparam logic signed [SW-1:0]     FASTS_S  = SW'(SPEED_FAST);
    localparam logic signed [SW-1:0]     PMIN_S   = SW'(PAD_MIN);
    localparam logic signed [SW-1:0]     PMAX_S   = SW'(PAD_MAX);

    typedef enum logic {
        S_FILL,
        S_TRACK
    } state_e;

    // Saturate a candidate paddle position into the legal range.
    function automatic logic [DATA_W-1:0] clamp_pad(input logic signed [SW-1:0] v);
        if (v < PMIN_S) begin
            return PMIN_S[DATA_W-1:0];
        end else if (v > PMAX_S) begin
            return PMAX_S[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    // Magnitude of a signed deviation; -2^(DATA_W-1) still fits in SW bits.
    function automatic logic [SW-1:0] abs_dev(input logic signed [SW-1:0] v);
        if (v[SW-1]) begin
            return $unsigned(-v);
        end else begin
            return $unsigned(v);
        end
    endfunction

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pad_q, pad_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic              up_q, up_d;
    logic              dn_q, dn_d;

    // Value avg_y takes on a sample_valid, and whether that sample primes
    // the filter when we are still filling.
    logic [DATA_W-1:0] avg_new;
    logic              fill_last;

`ifdef JOY_FILTER_EN
    logic [DATA_W-1:0] buf_q [4];
    logic [1:0]        cnt_q;
    logic [DATA_W+1:0] sum_new;

    // Sum of the buffer as it will be after this sample shifts in.
    always_comb begin
        sum_new = {2'b00, joy_y} + {2'b00, buf_q[0]}
                + {2'b00, buf_q[1]} + {2'b00, buf_q[2]};
        avg_new   = DATA_W'(sum_new >> 2);
        fill_last = (cnt_q == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= CENTER_U;
            end
            cnt_q <= 2'd0;
        end else if (sample_valid) begin
            buf_q[0] <= joy_y;
            for (int i = 1; i < 4; i++) begin
                buf_q[i] <= buf_q[i-1];
            end
            if (state_q == S_FILL) begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end
`else
    always_comb begin
        avg_new   = joy_y;
        fill_last = 1'b1;
    end
`endif

    // Frame step: deviation uses the avg_y registered before this cycle, so
    // a sample arriving together with frame_tick only affects the next frame.
    logic signed [SW-1:0] dev;
    logic [SW-1:0]        dev_mag;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] pad_s;

    always_comb begin
        dev     = $signed({1'b0, avg_q}) - CENTER_S;
        dev_mag = abs_dev(dev);
        step    = (dev_mag >= FAST_U) ? FASTS_S : SLOW_S;
        pad_s   = $signed({1'b0, pad_q});
    end

    always_comb begin
        state_d = state_q;
        avg_d   = avg_q;
        pad_d   = pad_q;
        up_d    = up_q;
        dn_d    = dn_q;

        if (sample_valid) begin
            avg_d = avg_new;
            if ((state_q == S_FILL) && fill_last) begin
                state_d = S_TRACK;
            end
        end

        if (recenter) begin
            pad_d = INIT_U;
            up_d  = 1'b0;
            dn_d  = 1'b0;
        end else if (frame_tick && (state_q == S_TRACK)) begin
            up_d = 1'b0;
            dn_d = 1'b0;
            if (enable && (dev_mag > DZ_U)) begin
                // Positive deflection moves the paddle up the screen.
                if (!dev[SW-1]) begin
                    pad_d = clamp_pad(pad_s - step);
                    up_d  = 1'b1;
                end else begin
                    pad_d = clamp_pad(pad_s + step);
                    dn_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_FILL;
            avg_q   <= CENTER_U;
            pad_q   <= INIT_U;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            avg_q   <= avg_d;
            pad_q   <= pad_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    assign pad_y       = pad_q;
    assign avg_y       = avg_q;
    assign moving_up   = up_q;
    assign moving_down = dn_q;
    assign ready       = (state_q == S_TRACK);

endmodule

// File: tb/tb_joy_paddle_ctrl.sv
module tb_joy_paddle_ctrl;

`ifdef JOY_FILTER_EN
    localparam int FILL_N = 4;
`else
    localparam int FILL_N = 1;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       sample_valid;
    logic [9:0] joy_y;
    logic       frame_tick;
    logic       enable;
    logic       recenter;
    logic [9:0] pad_y;
    logic [9:0] avg_y;
    logic       moving_up;
    logic       moving_down;
    logic       ready;

    always #5 clk = ~clk;

    joy_paddle_ctrl dut (
        .clk          (clk),
        .clr          (clr),
        .sample_valid (sample_valid),
        .joy_y        (joy_y),
        .frame_tick   (frame_tick),
        .enable       (enable),
        .recenter     (recenter),
        .pad_y        (pad_y),
        .avg_y        (avg_y),
        .moving_up    (moving_up),
        .moving_down  (moving_down),
        .ready        (ready)
    );

    typedef struct {
        int pad;
        int up;
        int dn;
        int rdy;
        int avg;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string phase = "init";

    // Reference model state
    int m_pad, m_avg, m_up, m_dn, m_rdy, m_cnt;
    int m_buf[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int c, input int sv, input int jy,
                              input int ft, input int en, input int rc);
        int old_avg, old_rdy, d, ad, st, sum;
        exp_t e;
        if (c != 0) begin
            m_pad = 200; m_avg = 512; m_up = 0; m_dn = 0; m_rdy = 0; m_cnt = 0;
            for (int i = 0; i < 4; i++) m_buf[i] = 512;
        end else begin
            old_avg = m_avg;
            old_rdy = m_rdy;
            if (sv != 0) begin
                if (FILL_N == 4) begin
                    m_buf[3] = m_buf[2]; m_buf[2] = m_buf[1];
                    m_buf[1] = m_buf[0]; m_buf[0] = jy;
                    sum = m_buf[0] + m_buf[1] + m_buf[2] + m_buf[3];
                    m_avg = sum / 4;
                end else begin
                    m_avg = jy;
                end
                if (old_rdy == 0) begin
                    m_cnt++;
                    if (m_cnt == FILL_N) m_rdy = 1;
                end
            end
            if (rc != 0) begin
                m_pad = 200; m_up = 0; m_dn = 0;
            end else if (ft != 0 && old_rdy != 0) begin
                m_up = 0; m_dn = 0;
                if (en != 0) begin
                    d  = old_avg - 512;
                    ad = (d < 0) ? -d : d;
                    if (ad > 64) begin
                        st = (ad >= 256) ? 6 : 2;
                        if (d > 0) begin
                            m_pad = m_pad - st;
                            if (m_pad < 0) m_pad = 0;
                            m_up = 1;
                        end else begin
                            m_pad = m_pad + st;
                            if (m_pad > 400) m_pad = 400;
                            m_dn = 1;
                        end
                    end
                end
            end
        end
        e.pad = m_pad; e.up = m_up; e.dn = m_dn; e.rdy = m_rdy; e.avg = m_avg;
        sb.push_back(e);
    endtask

    // One clock: drive inputs, push the expected result, then compare
    // the DUT outputs #1 after the edge against the popped entry.
    task automatic cyc(input int c, input int sv, input int jy,
                       input int ft, input int en, input int rc);
        exp_t e;
        clr          = (c != 0);
        sample_valid = (sv != 0);
        joy_y        = 10'(jy);
        frame_tick   = (ft != 0);
        enable       = (en != 0);
        recenter     = (rc != 0);
        model_step(c, sv, jy, ft, en, rc);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({phase, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({phase, "_pad"},  32'(pad_y),       e.pad);
            chk({phase, "_up"},   32'(moving_up),   e.up);
            chk({phase, "_dn"},   32'(moving_down), e.dn);
            chk({phase, "_rdy"},  32'(ready),       e.rdy);
            chk({phase, "_avg"},  32'(avg_y),       e.avg);
        end
    endtask

    task automatic samples(input int v, input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, v, 0, 1, 0);
    endtask

    task automatic ticks(input int en, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 512, 1, en, 0);
            cyc(0, 0, 512, 0, en, 0);
        end
    endtask

    initial begin
        clr = 1'b0; sample_valid = 1'b0; joy_y = 10'd512;
        frame_tick = 1'b0; enable = 1'b0; recenter = 1'b0;

        phase = "reset";
        cyc(1, 0, 512, 0, 0, 0);
        chk("reset_pad", 32'(pad_y), 200);
        chk("reset_avg", 32'(avg_y), 512);
        chk("reset_rdy", 32'(ready), 0);

        phase = "fill_tick";
        samples(900, FILL_N / 2);
        cyc(0, 0, 512, 1, 1, 0);
        chk("fill_tick_pad", 32'(pad_y), 200);
        chk("fill_tick_rdy", 32'(ready), 0);

        phase = "prime";
        samples(900, 4 - FILL_N / 2);
        chk("prime_rdy", 32'(ready), 1);
        chk("prime_avg", 32'(avg_y), 900);
        cyc(0, 0, 512, 1, 1, 0);
        chk("fast_pad", 32'(pad_y), 194);
        chk("fast_up",  32'(moving_up), 1);

        phase = "slow";
        cyc(0, 0, 512, 0, 1, 1);
        samples(600, 4);
        ticks(1, 10);
        chk("slow_pad", 32'(pad_y), 180);
        chk("slow_up",  32'(moving_up), 1);

        phase = "clamp_lo";
        samples(0, 4);
        ticks(1, 100);
        chk("clamp_lo_pad", 32'(pad_y), 400);
        chk("clamp_lo_dn",  32'(moving_down), 1);

        phase = "dead";
        samples(560, 4);
        ticks(1, 3);
        chk("dead_pad", 32'(pad_y), 400);
        chk("dead_dn",  32'(moving_down), 0);
        cyc(0, 0, 512, 1, 1, 1);
        chk("recenter_tick_pad", 32'(pad_y), 200);

        phase = "bounds";
        samples(576, 4); ticks(1, 1);
        chk("dz_pos_edge_pad", 32'(pad_y), 200);
        samples(448, 4); ticks(1, 1);
        chk("dz_neg_edge_pad", 32'(pad_y), 200);
        samples(577, 4); ticks(1, 1);
        chk("dz_plus1_pad", 32'(pad_y), 198);
        samples(768, 4); ticks(1, 1);
        chk("fast_edge_pad", 32'(pad_y), 192);
        samples(767, 4); ticks(1, 1);
        chk("fast_minus1_pad", 32'(pad_y), 190);

        phase = "disabled";
        samples(900, 4);
        ticks(0, 2);
        chk("disabled_pad", 32'(pad_y), 190);
        chk("disabled_up",  32'(moving_up), 0);

        phase = "sv_with_tick";
        cyc(0, 1, 100, 1, 1, 0);
        chk("sv_tick_pad", 32'(pad_y), 184);
        ticks(1, 2);

        phase = "clamp_hi";
        samples(1023, 4);
        ticks(1, 40);
        chk("clamp_hi_pad", 32'(pad_y), 0);
        chk("clamp_hi_up",  32'(moving_up), 1);

        phase = "clr_mid";
        cyc(1, 0, 512, 0, 1, 0);
        chk("clr_mid_rdy", 32'(ready), 0);
        chk("clr_mid_pad", 32'(pad_y), 200);
        cyc(0, 0, 512, 1, 1, 0);
        chk("clr_fill_tick_pad", 32'(pad_y), 200);
        ticks(1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
